// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the register-memory arbiter.
package mem_arb_pkg;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 6;
  localparam logic [7:0] ERR_DATA = 8'hFF;

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, RESP} state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the requester just after i_ptr has top
// priority, wrapping around. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  int cand;

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    cand  = 0;
    for (int k = N; k >= 1; k--) begin
      cand = (int'(i_ptr) + k) % N;
      if (i_req[cand]) begin
        o_gnt       = '0;
        o_gnt[cand] = 1'b1;
        o_idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a small register memory between NUM_REQ requesters, one transaction
// at a time, with round-robin grants and a one-cycle response pulse.
module mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = mem_arb_pkg::DEPTH,
  parameter int AW      = mem_arb_pkg::AW,
  parameter int DW      = mem_arb_pkg::DW
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ-1:0]    i_we,
  input  logic [NUM_REQ*AW-1:0] i_addr,
  input  logic [NUM_REQ*DW-1:0] i_wdata,
  output logic [NUM_REQ-1:0]    o_gnt,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  output logic [DW-1:0]         o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_reset,
  output logic                  o_mem_rd_wr,
  output logic [AW-1:0]         o_mem_addr,
  output logic [DW-1:0]         o_mem_wr_data,
  input  logic [DW-1:0]         i_mem_rd_data
);

  import mem_arb_pkg::*;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_owner;
  logic                 r_we;
  logic [NUM_REQ-1:0]   r_rspValid;
  logic [DW-1:0]        r_rspRdata;
  logic                 r_rspErr;
  logic                 r_memReset;
  logic                 r_memRdWr;
  logic [AW-1:0]        r_memAddr;
  logic [DW-1:0]        r_memWrData;

  logic [NUM_REQ-1:0]   w_arbGnt;
  logic [IW-1:0]        w_winIdx;
  logic [AW-1:0]        w_winAddr;
  logic [DW-1:0]        w_winData;
  logic                 w_winWe;
  logic                 w_winInRange;
  logic                 w_curInRange;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_arbGnt),
    .o_idx (w_winIdx)
  );

  assign w_winAddr    = i_addr[w_winIdx*AW +: AW];
  assign w_winData    = i_wdata[w_winIdx*DW +: DW];
  assign w_winWe      = i_we[w_winIdx];
  assign w_winInRange = 32'(w_winAddr) < DEPTH;
  assign w_curInRange = 32'(r_memAddr) < DEPTH;

  // The grant is combinational so the command is latched in the same cycle.
  assign o_gnt         = (r_state == IDLE) ? w_arbGnt : '0;
  assign o_rsp_valid   = r_rspValid;
  assign o_rsp_rdata   = r_rspRdata;
  assign o_rsp_err     = r_rspErr;
  assign o_mem_reset   = r_memReset;
  assign o_mem_rd_wr   = r_memRdWr;
  assign o_mem_addr    = r_memAddr;
  assign o_mem_wr_data = r_memWrData;

  // Memory-side signals are set on the edge entering ISSUE; rd_wr drops only
  // for an in-range write so every other cycle is a harmless read.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= INIT;
      r_ptr       <= IW'(NUM_REQ - 1);
      r_owner     <= '0;
      r_we        <= 1'b0;
      r_rspValid  <= '0;
      r_rspRdata  <= '0;
      r_rspErr    <= 1'b0;
      r_memReset  <= 1'b1;
      r_memRdWr   <= 1'b1;
      r_memAddr   <= '0;
      r_memWrData <= '0;
    end else begin
      r_rspValid <= '0;
      case (r_state)
        INIT: begin
          r_memReset <= 1'b0;
          r_state    <= IDLE;
        end
        IDLE: begin
          if (|i_req) begin
            r_ptr       <= w_winIdx;
            r_owner     <= w_winIdx;
            r_we        <= w_winWe;
            r_memAddr   <= w_winAddr;
            r_memWrData <= w_winData;
            r_memRdWr   <= !(w_winWe && w_winInRange);
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_memRdWr <= 1'b1;
          if (!w_curInRange) begin
            r_rspRdata          <= DW'(ERR_DATA);
            r_rspErr            <= 1'b1;
            r_rspValid[r_owner] <= 1'b1;
            r_state             <= RESP;
          end else if (r_we) begin
            r_rspRdata          <= '0;
            r_rspErr            <= 1'b0;
            r_rspValid[r_owner] <= 1'b1;
            r_state             <= RESP;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_rspRdata          <= i_mem_rd_data;
          r_rspErr            <= 1'b0;
          r_rspValid[r_owner] <= 1'b1;
          r_state             <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural register memory, scoreboard of expected
// responses keyed on grants, table-driven transactions plus corner sequences.
module tb_mem_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 3;
  localparam int DW      = 8;
  localparam int DEPTH   = 6;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    we;
  logic [NUM_REQ*AW-1:0] addr;
  logic [NUM_REQ*DW-1:0] wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rspValid;
  logic [DW-1:0]         rspRdata;
  logic                  rspErr;
  logic                  memReset;
  logic                  memRdWr;
  logic [AW-1:0]         memAddr;
  logic [DW-1:0]         memWrData;
  logic [DW-1:0]         memRdData;

  logic [7:0] memArray [DEPTH];
  logic [7:0] refMem   [DEPTH];

  typedef struct {
    int         owner;
    logic [7:0] rdata;
    logic       err;
    int         dueCycle;
  } exp_t;

  typedef struct {
    int         r;
    bit         w;
    int         a;
    logic [7:0] d;
    logic [7:0] expRdata;
    logic       expErr;
  } vec_t;

  exp_t sbQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;
  int   cycleCount  = 0;
  int   wrCycles    = 0;
  int   rspCount    = 0;
  logic [7:0] lastRdata;
  logic       lastErr;
  int         lastOwner;

  int         mW;
  logic [2:0] mA;
  exp_t       mE;

  mem_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_req         (req),
    .i_we          (we),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .o_gnt         (gnt),
    .o_rsp_valid   (rspValid),
    .o_rsp_rdata   (rspRdata),
    .o_rsp_err     (rspErr),
    .o_mem_reset   (memReset),
    .o_mem_rd_wr   (memRdWr),
    .o_mem_addr    (memAddr),
    .o_mem_wr_data (memWrData),
    .i_mem_rd_data (memRdData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Register memory: synchronous fill on reset, write whenever rd_wr is low.
  always @(posedge clk) begin
    if (memReset) begin
      for (int i = 0; i < DEPTH; i++) memArray[i] <= 8'hFF;
      memRdData <= 8'hFF;
    end else begin
      if (!memRdWr && 32'(memAddr) < DEPTH) memArray[memAddr] <= memWrData;
      memRdData <= (32'(memAddr) < DEPTH) ? memArray[memAddr] : 8'hFF;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: push on grant from the bench's own memory image, pop on response.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rspValid != '0) begin
        rspCount++;
        if (sbQ.size() == 0) begin
          checkOutput("unexpected rsp_valid", 32'(rspValid), 32'(0));
        end else begin
          mE = sbQ.pop_front();
          checkOutput("rsp owner", 32'(rspValid), 32'(1) << mE.owner);
          checkOutput("rsp rdata", 32'(rspRdata), 32'(mE.rdata));
          checkOutput("rsp err", 32'(rspErr), 32'(mE.err));
          checkOutput("rsp latency", cycleCount, mE.dueCycle);
          lastRdata = rspRdata;
          lastErr   = rspErr;
          lastOwner = rspValid[1] ? 1 : 0;
        end
      end
      if (gnt != '0) begin
        checkOutput("gnt onehot", 32'($onehot(gnt)), 32'(1));
        mW = gnt[1] ? 1 : 0;
        mA = addr[mW*AW +: AW];
        mE.owner = mW;
        if (32'(mA) >= DEPTH) begin
          mE.rdata = 8'hFF; mE.err = 1'b1; mE.dueCycle = cycleCount + 2;
        end else if (we[mW]) begin
          refMem[mA] = wdata[mW*DW +: DW];
          mE.rdata = 8'h00; mE.err = 1'b0; mE.dueCycle = cycleCount + 2;
        end else begin
          mE.rdata = refMem[mA]; mE.err = 1'b0; mE.dueCycle = cycleCount + 3;
        end
        sbQ.push_back(mE);
      end
      if (memRdWr == 1'b0) wrCycles++;
    end
  end

  task automatic applyStimulus(input int r, input bit w, input int a, input logic [7:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    we[r]             = w;
    addr[r*AW +: AW]  = a[2:0];
    wdata[r*DW +: DW] = d;
    req[r]            = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt[r]) got = 1'b1;
    end
    checkOutput("gnt seen", 32'(got), 32'(1));
    @(posedge clk); #1;
    req[r] = 1'b0;
  endtask

  task automatic waitResponse();
    int n = 0;
    while (sbQ.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rsp drained", sbQ.size(), 0);
  endtask

  task automatic doTxn(input string name, input int r, input bit w, input int a,
                       input logic [7:0] d, input logic [7:0] expRdata, input logic expErr);
    int wrBefore = wrCycles;
    applyStimulus(r, w, a, d);
    waitResponse();
    checkOutput({name, " rdata"}, 32'(lastRdata), 32'(expRdata));
    checkOutput({name, " err"}, 32'(lastErr), 32'(expErr));
    checkOutput({name, " owner"}, lastOwner, r);
    checkOutput({name, " write cycles"}, wrCycles - wrBefore, (w && a < DEPTH) ? 1 : 0);
  endtask

  task automatic checkMemImage(input string name);
    for (int i = 0; i < DEPTH; i++)
      checkOutput($sformatf("%s entry%0d", name, i), 32'(memArray[i]), 32'(refMem[i]));
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, " gnt"}, 32'(gnt), 32'(0));
    checkOutput({name, " rsp_valid"}, 32'(rspValid), 32'(0));
    checkOutput({name, " rsp_rdata"}, 32'(rspRdata), 32'(0));
    checkOutput({name, " rsp_err"}, 32'(rspErr), 32'(0));
    checkOutput({name, " mem_reset"}, 32'(memReset), 32'(1));
    checkOutput({name, " mem_rd_wr"}, 32'(memRdWr), 32'(1));
    checkOutput({name, " mem_addr"}, 32'(memAddr), 32'(0));
    checkOutput({name, " mem_wr_data"}, 32'(memWrData), 32'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[11];
    int   wrBefore;
    int   rspBefore;
    bit   got;
    int   w;

    vecs[0]  = '{0, 1'b0, 3, 8'h00, 8'hFF, 1'b0};
    vecs[1]  = '{1, 1'b1, 2, 8'hA5, 8'h00, 1'b0};
    vecs[2]  = '{1, 1'b0, 2, 8'h00, 8'hA5, 1'b0};
    vecs[3]  = '{0, 1'b1, 7, 8'h12, 8'hFF, 1'b1};
    vecs[4]  = '{0, 1'b1, 5, 8'h3C, 8'h00, 1'b0};
    vecs[5]  = '{1, 1'b0, 5, 8'h00, 8'h3C, 1'b0};
    vecs[6]  = '{0, 1'b0, 0, 8'h00, 8'hFF, 1'b0};
    vecs[7]  = '{1, 1'b1, 6, 8'h99, 8'hFF, 1'b1};
    vecs[8]  = '{0, 1'b0, 6, 8'h00, 8'hFF, 1'b1};
    vecs[9]  = '{0, 1'b1, 0, 8'h11, 8'h00, 1'b0};
    vecs[10] = '{1, 1'b0, 0, 8'h00, 8'h11, 1'b0};

    reset_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("mem_reset first cycle", 32'(memReset), 32'(1));
    @(negedge clk);
    checkOutput("mem_reset after init", 32'(memReset), 32'(0));

    foreach (vecs[i])
      doTxn($sformatf("row%0d", i), vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d,
            vecs[i].expRdata, vecs[i].expErr);
    checkMemImage("after table");

    // Both requesters hold req; last grant above went to 1, so 0 leads.
    @(posedge clk); #1;
    we    = 2'b11;
    addr  = {3'd1, 3'd0};
    wdata = {8'h41, 8'h40};
    req   = 2'b11;
    for (int i = 0; i < 6; i++) begin
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (gnt != '0) got = 1'b1;
      end
      checkOutput($sformatf("contention gnt%0d", i), 32'(gnt), 32'(1) << (i % 2));
      w = gnt[1] ? 1 : 0;
      @(posedge clk); #1;
      wdata[w*DW +: DW] = 8'(8'h42 + i);
      if (i == 5) req = '0;
    end
    waitResponse();
    doTxn("final read0", 0, 1'b0, 0, 8'h00, 8'h44, 1'b0);
    doTxn("final read1", 1, 1'b0, 1, 8'h00, 8'h45, 1'b0);

    wrBefore  = wrCycles;
    rspBefore = rspCount;
    repeat (50) @(negedge clk);
    checkOutput("idle write cycles", wrCycles - wrBefore, 0);
    checkOutput("idle rsp count", rspCount - rspBefore, 0);
    checkMemImage("after idle");

    // Abort a read while it sits in WAIT.
    rspBefore = rspCount;
    applyStimulus(0, 1'b0, 2, 8'h00);
    @(posedge clk); #1;
    reset_n = 1'b0;
    sbQ.delete();
    #1;
    checkResetOutputs("mid reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) refMem[i] = 8'hFF;
    repeat (4) @(negedge clk);
    checkOutput("no rsp after abort", rspCount - rspBefore, 0);
    doTxn("post reset read2", 0, 1'b0, 2, 8'h00, 8'hFF, 1'b0);
    doTxn("post reset read0", 1, 1'b0, 0, 8'h00, 8'hFF, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
